// File: rtl/wam_key_pkg.sv
// Shared definitions for the keypad debouncer: per-channel FSM state
// encoding, the idle level of a raw column line and a counter-width helper.
package wam_key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_e;

  // Raw column lines are active-low, so an untouched key reads high.
  localparam logic COLUMN_IDLE = 1'b1;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: 2-flop synchroniser on the raw active-low
// column line, a counter-qualified 4-state FSM producing a clean level and
// registered press/release pulses, and an optional auto-repeat timer.
// Build option: define KEY_REPEAT_EN to include the auto-repeat timer;
// without it key_repeat_o is tied low.
//
// state        | meaning
// RELEASED     | stable released, waiting for a pressed sample
// PRESS_WAIT   | counting consecutive pressed samples
// PRESSED      | stable pressed, waiting for a released sample
// RELEASE_WAIT | counting consecutive released samples (level still pressed)
module key_debounce_chan
  import wam_key_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic column_i,
  output logic key_down_o,
  output logic key_pressed_o,
  output logic key_released_o,
  output logic key_repeat_o
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic       s1_q, s2_q;
  logic       pressed_raw;
  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;

  // Two-flop synchroniser; both stages come out of reset at the idle level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= COLUMN_IDLE;
      s2_q <= COLUMN_IDLE;
    end else begin
      s1_q <= column_i;
      s2_q <= s1_q;
    end
  end

  assign pressed_raw = ~s2_q;

  // State, qualification counter and edge pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  // Next state: a level is accepted after STABLE_CYCLES consecutive samples.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (pressed_raw) begin
          if (STABLE_CYCLES == 1) begin
            state_d   = PRESSED;
            pressed_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!pressed_raw) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!pressed_raw) begin
          if (STABLE_CYCLES == 1) begin
            state_d    = RELEASED;
            released_d = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed_raw) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RELEASED;
          cnt_d      = '0;
          released_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: the debounced level stays high while a release is being qualified.
  always_comb begin
    key_down_o     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    key_pressed_o  = pressed_q;
    key_released_o = released_q;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = cnt_width(REP_MAX);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          repeat_q, repeat_d;
  logic          down_next;

  // Repeat timer register; reset and release both silence it at once.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  // Down-counter loaded on the press edge, reloaded with the period at each pulse.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    repeat_d  = 1'b0;
    down_next = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    if (pressed_d) begin
      rep_cnt_d = RW'(REPEAT_DELAY - 1);
    end else if (key_down_o && down_next) begin
      if (rep_cnt_q == '0) begin
        repeat_d  = 1'b1;
        rep_cnt_d = RW'(REPEAT_PERIOD - 1);
      end else begin
        rep_cnt_d = rep_cnt_q - RW'(1);
      end
    end else if (!down_next) begin
      rep_cnt_d = '0;
    end
  end

  assign key_repeat_o = repeat_q;
`else
  // The repeat settings stay referenced so both builds share one parameter set.
  localparam bit REPEAT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
  assign key_repeat_o = REPEAT_CFG_OK & 1'b0;
`endif

endmodule

// File: rtl/key_debouncer_multi.sv
// N-channel keypad debouncer: one key_debounce_chan per raw column line plus
// an any-key-down summary. Build option: define KEY_REPEAT_EN to enable
// per-channel auto-repeat pulses on key_repeat.
module key_debouncer_multi
  import wam_key_pkg::*;
#(
  parameter int NUM_KEYS      = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] column,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_down
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk_i         (clk),
      .reset_i       (reset),
      .column_i      (column[k]),
      .key_down_o    (key_down[k]),
      .key_pressed_o (key_pressed[k]),
      .key_released_o(key_released[k]),
      .key_repeat_o  (key_repeat[k])
    );
  end

  // Any debounced key held.
  always_comb begin
    any_down = |key_down;
  end

endmodule

// File: tb/tb_key_debouncer_multi.sv
module tb_key_debouncer_multi;
  localparam int NK = 3;
  localparam int SC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] column = '1;
  logic [NK-1:0] key_down, key_pressed, key_released, key_repeat;
  logic          any_down;

  key_debouncer_multi #(
    .NUM_KEYS(NK), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .column(column),
    .key_down(key_down), .key_pressed(key_pressed), .key_released(key_released),
    .key_repeat(key_repeat), .any_down(any_down)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] down;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] rp;
    logic          any;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: a key's level flips once SC consecutive synchronised
  // samples disagree with it; repeats fall at RD + k*RP cycles after the press.
  logic [NK-1:0] m_s1, m_s2, m_level;
  int m_run[NK];
  int m_since[NK];

  always @(posedge clk) begin
    exp_t e;
    logic [NK-1:0] p;
    e = '0;
    if (reset) begin
      m_s1 = '1;
      m_s2 = '1;
      m_level = '0;
      for (int c = 0; c < NK; c++) begin
        m_run[c] = 0;
        m_since[c] = 0;
      end
    end else begin
      p = ~m_s2;
      for (int c = 0; c < NK; c++) begin
        if (p[c] != m_level[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == SC) begin
          m_run[c] = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            e.pr[c] = 1'b1;
            m_since[c] = 0;
          end else begin
            e.rl[c] = 1'b1;
          end
        end else if (m_level[c]) begin
          m_since[c]++;
        end
`ifdef KEY_REPEAT_EN
        if (m_level[c] && !e.pr[c] && m_since[c] >= RD && ((m_since[c] - RD) % RP) == 0)
          e.rp[c] = 1'b1;
`endif
      end
      m_s2 = m_s1;
      m_s1 = column;
    end
    e.down = m_level;
    e.any = |m_level;
    sb_q.push_back(e);
  end

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
    end
  endtask

  // Monitor: outputs settle after the rising edge; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("key_down", key_down, e.down);
      check("key_pressed", key_pressed, e.pr);
      check("key_released", key_released, e.rl);
      check("key_repeat", key_repeat, e.rp);
      check("any_down", {{(NK-1){1'b0}}, any_down}, {{(NK-1){1'b0}}, e.any});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int hold[NK];

  initial begin
    // reset, then idle
    reset = 1'b1; column = 3'b111; cyc(2);
    reset = 1'b0; cyc(20);
    // single press on key 1
    column[1] = 1'b0; cyc(12);
    // bounce on key 0 then held
    column[0] = 1'b0; cyc(3); column[0] = 1'b1; cyc(1);
    column[0] = 1'b0; cyc(3); column[0] = 1'b1; cyc(1);
    column[0] = 1'b0; cyc(12);
    // key 1: short high glitch rejected, then real release
    column[1] = 1'b1; cyc(2); column[1] = 1'b0; cyc(8);
    column[1] = 1'b1; cyc(10);
    column[0] = 1'b1; cyc(10);
    // simultaneous press of keys 0 and 2
    column = 3'b010; cyc(10);
    column = 3'b111; cyc(10);
    // reset while a release is being qualified
    column[1] = 1'b0; cyc(10);
    column[1] = 1'b1; cyc(3);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(10);
    // long hold for auto-repeat, then release
    column[0] = 1'b0; cyc(30);
    column[0] = 1'b1; cyc(15);
    // randomised bouncing on all keys with occasional reset
    for (int c = 0; c < NK; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NK; c++) begin
        if (hold[c] == 0) begin
          column[c] = ~column[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6);
        end else begin
          hold[c]--;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    reset = 1'b0; column = '1; cyc(12);
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
